unified_memory: RTL and testbench

Parametrised successor to the split instruction/data memory pair: one single-ported word array shared by the fetch port and the data port of the pipelined processor. It serialises requests with contention-fair arbitration and a configurable access latency. It drives per-port stall signals straight to the hazard unit. It sits between `MainProcessor` and the storage, replacing the separate fixed-latency memories in `Top`.

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 40 ++++
 rtl/unified_memory.sv | 110 +++++++++++
 tb/tb_unified_memory.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the unified instruction/data memory: FSM states, port ownership, latency bound.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;
   localparam int MAX_LATENCY = 4;
endpackage

// File: rtl/mem_array.sv
// Single-ported word storage with synchronous write and registered read; one access per enabled edge.
// Out-of-range accesses read as 0, never write, and raise oor for the response cycle.
module mem_array #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              oor
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
   assign idx      = addr[IDX_W-1:0];

   // Contents are deliberately not reset; they survive a core reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we && in_range) begin
            mem[idx] <= wdata;
         end
         rdata <= (!we && in_range) ? mem[idx] : '0;
         oor   <= !in_range;
      end
   end

   function automatic logic [DATA_W-1:0] printMemory(input logic [IDX_W-1:0] i);
      return mem[i];
   endfunction
endmodule

// File: rtl/unified_memory.sv
// Shared fetch/data memory: fair arbiter, IDLE/BUSY/RESP FSM, response LATENCY cycles after acceptance.
// Requesters hold req until their one-cycle ready pulse; stall_f/stall_m feed the hazard unit directly.
module unified_memory
   import mem_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_err,
   output logic              stall_f,
   output logic              stall_m
);
   localparam int LAT   = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : ((LATENCY < 1) ? 1 : LATENCY);
   localparam int CNT_W = $clog2(LAT + 1);

   state_t            state, state_nxt;
   owner_t            owner;
   logic              prev_vld;
   logic [CNT_W-1:0]  cnt;
   logic              if_elig, d_elig, grant_if, grant_d, accept;
   logic              arr_en, arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_rdata;
   logic              arr_oor;

   // In RESP only the port not being answered may be accepted.
   assign if_elig  = if_req && (state == IDLE || (state == RESP && owner == OWN_D));
   assign d_elig   = d_req  && (state == IDLE || (state == RESP && owner == OWN_IF));
   assign grant_if = if_elig && (!d_elig || (prev_vld && owner == OWN_D));
   assign grant_d  = d_elig && !grant_if;
   assign accept   = grant_if || grant_d;

   assign arr_en   = accept && reset;
   assign arr_we   = grant_d && d_we;
   assign arr_addr = grant_if ? if_addr : d_addr;

   mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (d_wdata),
      .rdata (arr_rdata),
      .oor   (arr_oor)
   );

   // owner doubles as the previous-grant record once prev_vld is set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= OWN_D;
         prev_vld <= 1'b0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner    <= grant_if ? OWN_IF : OWN_D;
            prev_vld <= 1'b1;
            cnt      <= CNT_W'(LAT - 1);
         end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (LAT == 1) ? RESP : BUSY;
         BUSY:    if (cnt == CNT_W'(1)) state_nxt = RESP;
         RESP:    state_nxt = accept ? ((LAT == 1) ? RESP : BUSY) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if_ready = 1'b0;
      d_ready  = 1'b0;
      d_err    = 1'b0;
      if_rdata = '0;
      d_rdata  = '0;
      if (state == RESP) begin
         if (owner == OWN_IF) begin
            if_ready = 1'b1;
            if_rdata = arr_rdata;
         end else begin
            d_ready = 1'b1;
            d_rdata = arr_rdata;
            d_err   = arr_oor;
         end
      end
   end

   assign stall_f = if_req & ~if_ready;
   assign stall_m = d_req & ~d_ready;
endmodule

// File: tb/tb_unified_memory.sv
// Bench for unified_memory: one instance per LATENCY 1..4, scoreboard of expected responses with due cycles.
module tb_unified_memory;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [4:1]  if_req, if_ready, d_req, d_we, d_ready, d_err, stall_f, stall_m;
   logic [15:0] if_addr [1:4];
   logic [15:0] if_rdata[1:4];
   logic [15:0] d_addr  [1:4];
   logic [15:0] d_wdata [1:4];
   logic [15:0] d_rdata [1:4];

   for (genvar L = 1; L <= 4; L++) begin : g_dut
      unified_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(L)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .if_req   (if_req[L]),
         .if_addr  (if_addr[L]),
         .if_rdata (if_rdata[L]),
         .if_ready (if_ready[L]),
         .d_req    (d_req[L]),
         .d_we     (d_we[L]),
         .d_addr   (d_addr[L]),
         .d_wdata  (d_wdata[L]),
         .d_rdata  (d_rdata[L]),
         .d_ready  (d_ready[L]),
         .d_err    (d_err[L]),
         .stall_f  (stall_f[L]),
         .stall_m  (stall_m[L])
      );
   end

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      bit          is_d;
      bit          chk_data;
      logic [15:0] data;
      bit          err;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   // Waits (bounded) for the ready pulse of one port; optionally drops that port's req at the pulse.
   task automatic wait_resp(input int k, input bit is_d, input bit keep,
                            output bit ok, output int at, output logic [15:0] rd, output logic er);
      ok = 1'b0; at = -1; rd = '0; er = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (is_d ? d_ready[k] : if_ready[k]) begin
            ok = 1'b1;
            at = edge_n;
            rd = is_d ? d_rdata[k] : if_rdata[k];
            er = d_err[k];
            if (!keep) begin
               if (is_d) d_req[k] = 1'b0;
               else      if_req[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({if_ready[k], d_ready[k], d_err[k], stall_f[k], stall_m[k]} !== 5'b0 ||
             if_rdata[k] !== 16'h0 || d_rdata[k] !== 16'h0)
            $display("FAIL reset_outputs L=%0d: rdy=%b/%b err=%b stall=%b/%b rdata=%h/%h, want all 0",
                     k, if_ready[k], d_ready[k], d_err[k], stall_f[k], stall_m[k], if_rdata[k], d_rdata[k]);
         else passed++;
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_then_read();
      bit ok; int at; logic [15:0] rd; logic er; exp_t e;
      @(negedge clk);
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 16'd5; d_wdata[1] = 16'hBEEF;
      sb.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 16'h0, err: 1'b0, due: edge_n + 1});
      wait_resp(1, 1'b1, 1'b0, ok, at, rd, er);
      e = sb.pop_front();
      checks++;
      if (!ok || at != e.due || er !== e.err)
         $display("FAIL wr_beef_resp: seen=%0d at=%0d err=%b, want at=%0d err=%b", ok, at, er, e.due, e.err);
      else passed++;
      // IF issued during D's ready cycle is accepted at that RESP edge
      if_req[1] = 1'b1; if_addr[1] = 16'd5;
      sb.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hBEEF, err: 1'b0, due: edge_n + 1});
      wait_resp(1, 1'b0, 1'b0, ok, at, rd, er);
      e = sb.pop_front();
      checks++;
      if (!ok || at != e.due)
         $display("FAIL rd_beef_timing: seen=%0d at=%0d, want at=%0d", ok, at, e.due);
      else passed++;
      checks++;
      if (rd !== e.data) $display("FAIL rd_beef_data: got %h want %h", rd, e.data);
      else passed++;
      @(negedge clk);
      checks++;
      if (if_ready[1] !== 1'b0 || if_rdata[1] !== 16'h0)
         $display("FAIL rd_beef_after: rdy=%b rdata=%h, want 0/0000", if_ready[1], if_rdata[1]);
      else passed++;
   endtask

   task automatic test_contention();
      bit ok; int at; logic [15:0] rd; logic er; exp_t e;
      logic [15:0] wa [2] = '{16'd2, 16'd7};
      logic [15:0] wd [2] = '{16'h1234, 16'h5678};
      int stall_bad = 0;
      bit got_d;
      logic [15:0] got;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         d_req[3] = 1'b1; d_we[3] = 1'b1; d_addr[3] = wa[i]; d_wdata[3] = wd[i];
         wait_resp(3, 1'b1, 1'b0, ok, at, rd, er);
         checks++;
         if (!ok) $display("FAIL contention_setup_write %0d: no d_ready, want one", i);
         else passed++;
      end
      // Reset forgets the previous grant but keeps the array
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      d_req[3] = 1'b1; d_we[3] = 1'b0; d_addr[3] = 16'd2;
      if_req[3] = 1'b1; if_addr[3] = 16'd7;
      sb.push_back('{is_d: 1'b1, chk_data: 1'b1, data: 16'h1234, err: 1'b0, due: edge_n + 3});
      sb.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'h5678, err: 1'b0, due: edge_n + 6});
      for (int i = 0; i < 15 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (stall_f[3] !== (if_req[3] && !if_ready[3])) stall_bad++;
         if (d_ready[3] || if_ready[3]) begin
            e = sb.pop_front();
            got_d = d_ready[3];
            got = got_d ? d_rdata[3] : if_rdata[3];
            checks++;
            if ({d_ready[3], if_ready[3]} !== {e.is_d, !e.is_d} || edge_n != e.due || got !== e.data)
               $display("FAIL contention_resp: rdy d/if=%b%b at=%0d data=%h, want %b%b at=%0d data=%h",
                        d_ready[3], if_ready[3], edge_n, got, e.is_d, !e.is_d, e.due, e.data);
            else passed++;
            if (got_d) d_req[3] = 1'b0;
            else       if_req[3] = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) $display("FAIL contention_timeout: %0d responses missing, want 0", sb.size());
      else passed++;
      checks++;
      if (stall_bad != 0) $display("FAIL contention_stall_f: %0d bad cycles, want 0", stall_bad);
      else passed++;
      sb.delete();
      d_req[3] = 1'b0; if_req[3] = 1'b0;
   endtask

   task automatic test_fairness();
      exp_t e;
      logic [15:0] got;
      @(negedge clk);
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'd5;
      if_req[1] = 1'b1; if_addr[1] = 16'd5;
      for (int i = 0; i < 6; i++)
         sb.push_back('{is_d: (i % 2 == 0), chk_data: 1'b1, data: 16'hBEEF, err: 1'b0, due: edge_n + 1 + i});
      for (int i = 0; i < 12 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (d_ready[1] || if_ready[1]) begin
            e = sb.pop_front();
            got = d_ready[1] ? d_rdata[1] : if_rdata[1];
            checks++;
            if ({d_ready[1], if_ready[1]} !== {e.is_d, !e.is_d} || edge_n != e.due || got !== e.data)
               $display("FAIL fairness_grant: rdy d/if=%b%b at=%0d data=%h, want %b%b at=%0d data=%h",
                        d_ready[1], if_ready[1], edge_n, got, e.is_d, !e.is_d, e.due, e.data);
            else passed++;
            if (sb.size() == 0) begin
               d_req[1] = 1'b0; if_req[1] = 1'b0;
            end
         end
      end
      checks++;
      if (sb.size() != 0) $display("FAIL fairness_timeout: %0d grants missing, want 0", sb.size());
      else passed++;
      sb.delete();
      d_req[1] = 1'b0; if_req[1] = 1'b0;
   endtask

   task automatic test_out_of_range();
      bit ok; int at; logic [15:0] rd; logic er; exp_t e;
      logic        op_we  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] op_a   [7] = '{16'd0, 16'd256, 16'd256, 16'd0, 16'hFFFF, 16'd255, 16'd255};
      logic [15:0] op_wd  [7] = '{16'h1111, 16'hDEAD, 16'h0, 16'h0, 16'h0, 16'h2552, 16'h0};
      logic [15:0] op_exp [7] = '{16'h0, 16'h0, 16'h0, 16'h1111, 16'h0, 16'h0, 16'h2552};
      logic        op_err [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (d_err[2] !== 1'b0 || d_rdata[2] !== 16'h0)
            $display("FAIL oor_quiet %0d: err=%b rdata=%h between responses, want 0/0000", i, d_err[2], d_rdata[2]);
         else passed++;
         d_req[2] = 1'b1; d_we[2] = op_we[i]; d_addr[2] = op_a[i]; d_wdata[2] = op_wd[i];
         sb.push_back('{is_d: 1'b1, chk_data: !op_we[i], data: op_exp[i], err: op_err[i], due: edge_n + 2});
         wait_resp(2, 1'b1, 1'b0, ok, at, rd, er);
         e = sb.pop_front();
         checks++;
         if (!ok || at != e.due || er !== e.err || (e.chk_data && rd !== e.data))
            $display("FAIL oor_op %0d addr=%h: seen=%0d at=%0d err=%b data=%h, want at=%0d err=%b data=%h",
                     i, op_a[i], ok, at, er, rd, e.due, e.err, e.data);
         else passed++;
      end
   endtask

   task automatic test_reset_busy();
      bit ok; int at; logic [15:0] rd; logic er; exp_t e;
      int saw_ready = 0;
      @(negedge clk);
      d_req[4] = 1'b1; d_we[4] = 1'b1; d_addr[4] = 16'd9; d_wdata[4] = 16'h4242;
      wait_resp(4, 1'b1, 1'b0, ok, at, rd, er);
      checks++;
      if (!ok) $display("FAIL reset_busy_setup: no d_ready, want one");
      else passed++;
      @(negedge clk);
      d_req[4] = 1'b1; d_we[4] = 1'b0; d_addr[4] = 16'd9;
      sb.push_back('{is_d: 1'b1, chk_data: 1'b1, data: 16'h4242, err: 1'b0, due: edge_n + 4});
      repeat (2) @(negedge clk);
      reset = 1'b0; d_req[4] = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({if_ready[4], d_ready[4], d_err[4]} !== 3'b0 || if_rdata[4] !== 16'h0 || d_rdata[4] !== 16'h0)
         $display("FAIL reset_busy_outputs: rdy=%b/%b err=%b rdata=%h/%h, want all 0",
                  if_ready[4], d_ready[4], d_err[4], if_rdata[4], d_rdata[4]);
      else passed++;
      repeat (2) begin @(negedge clk); if (d_ready[4] || if_ready[4]) saw_ready++; end
      reset = 1'b1;
      repeat (5) begin @(negedge clk); if (d_ready[4] || if_ready[4]) saw_ready++; end
      checks++;
      if (saw_ready != 0) $display("FAIL reset_busy_abandon: %0d ready cycles, want 0", saw_ready);
      else passed++;
      d_req[4] = 1'b1; d_we[4] = 1'b0; d_addr[4] = 16'd9;
      sb.push_back('{is_d: 1'b1, chk_data: 1'b1, data: 16'h4242, err: 1'b0, due: edge_n + 4});
      wait_resp(4, 1'b1, 1'b0, ok, at, rd, er);
      e = sb.pop_front();
      checks++;
      if (!ok || at != e.due || rd !== e.data)
         $display("FAIL reset_busy_fresh: seen=%0d at=%0d data=%h, want at=%0d data=%h", ok, at, rd, e.due, e.data);
      else passed++;
   endtask

   task automatic test_held_req();
      bit          exp_rdy;
      logic [15:0] exp_dat;
      @(negedge clk);
      if_req[2] = 1'b1; if_addr[2] = 16'd0;
      for (int i = 0; i < 3; i++)
         sb.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'h1111, err: 1'b0, due: edge_n + 2 + 3 * i});
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_rdy = (sb.size() != 0) && (sb[0].due == edge_n);
         exp_dat = exp_rdy ? sb[0].data : 16'h0;
         checks++;
         if (if_ready[2] !== exp_rdy || if_rdata[2] !== exp_dat)
            $display("FAIL held_req cycle %0d: rdy=%b rdata=%h, want %b/%h", i, if_ready[2], if_rdata[2], exp_rdy, exp_dat);
         else passed++;
         if (exp_rdy) void'(sb.pop_front());
      end
      if_req[2] = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset = 1'b0;
      if_req = '0; d_req = '0; d_we = '0;
      for (int k = 1; k <= 4; k++) begin
         if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      test_reset();
      test_write_then_read();
      test_contention();
      test_fairness();
      test_out_of_range();
      test_reset_busy();
      test_held_req();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1);
   end
endmodule
